pixel_stream_feeder: RTL and testbench



---
 rtl/face_detect_pkg.sv | 21 ++
 rtl/pixel_stream_feeder_if.sv | 36 +++
 rtl/pixel_fifo_sync.sv | 63 ++++++
 rtl/pixel_stream_feeder.sv | 118 +++++++++++
 tb/tb_pixel_stream_feeder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/face_detect_pkg.sv
// Shared constants and helpers for the face-detection pixel path.
// Exports default pixel/coordinate widths, default frame geometry, FIFO and
// stall counter defaults, and a constant clog2 helper for sizing counters.
package face_detect_pkg;

  localparam int unsigned DATA_WIDTH_12    = 12;
  localparam int unsigned COORD_WIDTH_DEF  = 12;
  localparam int unsigned FRAME_WIDTH_DEF  = 100;
  localparam int unsigned FRAME_HEIGHT_DEF = 24;
  localparam int unsigned FIFO_DEPTH_DEF   = 16;
  localparam int unsigned STALL_WIDTH_DEF  = 16;

  // Smallest r with 2**r >= value (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/pixel_stream_feeder_if.sv
// Pixel handshake bundle between the upstream writer, the feeder and the detector.
// Upstream side : i_pixel, i_pixel_valid -> feeder ; o_pixel_ready <- feeder
// Detector side : i_pixel_request -> feeder ; o_pixel, o_pixel_valid, o_x, o_y,
//                 o_frame_start, o_frame_end <- feeder
// modport slave is the feeder, modport master is the environment driving it.
interface pixel_stream_feeder_if
  import face_detect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_12,
  parameter int unsigned COORD_WIDTH = COORD_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0]  i_pixel;
  logic                   i_pixel_valid;
  logic                   o_pixel_ready;
  logic                   i_pixel_request;
  logic [DATA_WIDTH-1:0]  o_pixel;
  logic                   o_pixel_valid;
  logic [COORD_WIDTH-1:0] o_x;
  logic [COORD_WIDTH-1:0] o_y;
  logic                   o_frame_start;
  logic                   o_frame_end;

  modport slave (
    input  i_pixel, i_pixel_valid, i_pixel_request,
    output o_pixel_ready, o_pixel, o_pixel_valid, o_x, o_y,
           o_frame_start, o_frame_end
  );

  modport master (
    output i_pixel, i_pixel_valid, i_pixel_request,
    input  o_pixel_ready, o_pixel, o_pixel_valid, o_x, o_y,
           o_frame_start, o_frame_end
  );

endinterface

// File: rtl/pixel_fifo_sync.sv
// Single-clock FIFO with flush, full/empty/level and registered read data.
// Ports: clk_fpga/reset_fpga (async, active-high); flush_i clears pointers;
// push_i/wr_data_i write (ignored when full); pop_i reads into rd_data_o the
// next cycle (ignored when empty); full_o, empty_o, level_o report occupancy.
module pixel_fifo_sync
  import face_detect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_12,
  parameter int unsigned DEPTH      = FIFO_DEPTH_DEF,
  localparam int unsigned ADDR_W    = clog2(DEPTH),
  localparam int unsigned LEVEL_W   = clog2(DEPTH + 1)
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [LEVEL_W-1:0]    level_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_W:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic                    do_push_c, do_pop_c;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign level_o   = LEVEL_W'(wr_ptr_q - rd_ptr_q);
  assign rd_data_o = rd_data_q;

  assign do_push_c = push_i && !full_o && !flush_i;
  assign do_pop_c  = pop_i && !empty_o && !flush_i;

  // Storage array, no reset needed.
  always_ff @(posedge clk_fpga) begin
    if (do_push_c) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
  end

  // Pointers and read register.
  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
      if (do_pop_c) begin
        rd_ptr_q  <= rd_ptr_q + (ADDR_W+1)'(1);
        rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
    end
  end

endmodule

// File: rtl/pixel_stream_feeder.sv
// Buffers upstream pixels and hands one to the detector per request cycle,
// tagged with raster coordinates and frame start/end markers.
// Ports: clk_fpga, reset_fpga (async, active-high), i_flush (sync clear),
// pix_if (slave side of the pixel bundle), o_fifo_level (occupancy),
// o_stall_count (saturating count of request cycles that found no data).
module pixel_stream_feeder
  import face_detect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_12,
  parameter int unsigned COORD_WIDTH  = COORD_WIDTH_DEF,
  parameter int unsigned FRAME_WIDTH  = FRAME_WIDTH_DEF,
  parameter int unsigned FRAME_HEIGHT = FRAME_HEIGHT_DEF,
  parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
  parameter int unsigned STALL_WIDTH  = STALL_WIDTH_DEF,
  localparam int unsigned LEVEL_WIDTH = clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  input  logic                   i_flush,
  pixel_stream_feeder_if.slave   pix_if,
  output logic [LEVEL_WIDTH-1:0] o_fifo_level,
  output logic [STALL_WIDTH-1:0] o_stall_count
);

  logic                   fifo_full, fifo_empty;
  logic                   push_c, pop_c, stall_c, line_end_c, last_line_c;
  logic [COORD_WIDTH-1:0] nx_q, nx_d, ny_q, ny_d;
  logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic                   valid_q, valid_d, fs_q, fs_d, fe_q, fe_d;
  logic [STALL_WIDTH-1:0] stall_q, stall_d;

  // Ready follows full only, so a same-cycle pop never opens the door early.
  assign pix_if.o_pixel_ready = !fifo_full;

  assign push_c      = pix_if.i_pixel_valid && !fifo_full && !i_flush;
  assign pop_c       = pix_if.i_pixel_request && !fifo_empty && !i_flush;
  assign stall_c     = pix_if.i_pixel_request && fifo_empty && !i_flush;
  assign line_end_c  = (nx_q == COORD_WIDTH'(FRAME_WIDTH - 1));
  assign last_line_c = (ny_q == COORD_WIDTH'(FRAME_HEIGHT - 1));

  pixel_fifo_sync #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .flush_i    (i_flush),
    .push_i     (push_c),
    .wr_data_i  (pix_if.i_pixel),
    .pop_i      (pop_c),
    .rd_data_o  (pix_if.o_pixel),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (o_fifo_level)
  );

  // Next-coordinate advance, delivery tags and stall counter.
  always_comb begin
    nx_d    = nx_q;
    ny_d    = ny_q;
    x_d     = x_q;
    y_d     = y_q;
    valid_d = 1'b0;
    fs_d    = 1'b0;
    fe_d    = 1'b0;
    stall_d = stall_q;
    if (i_flush) begin
      nx_d    = '0;
      ny_d    = '0;
      stall_d = '0;
    end else begin
      if (pop_c) begin
        valid_d = 1'b1;
        x_d     = nx_q;
        y_d     = ny_q;
        fs_d    = (nx_q == '0) && (ny_q == '0);
        fe_d    = line_end_c && last_line_c;
        if (line_end_c) begin
          nx_d = '0;
          ny_d = last_line_c ? '0 : ny_q + COORD_WIDTH'(1);
        end else begin
          nx_d = nx_q + COORD_WIDTH'(1);
        end
      end
      if (stall_c && (stall_q != '1)) stall_d = stall_q + STALL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      nx_q    <= '0;
      ny_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
      stall_q <= '0;
    end else begin
      nx_q    <= nx_d;
      ny_q    <= ny_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
      stall_q <= stall_d;
    end
  end

  assign pix_if.o_pixel_valid = valid_q;
  assign pix_if.o_x           = x_q;
  assign pix_if.o_y           = y_q;
  assign pix_if.o_frame_start = fs_q;
  assign pix_if.o_frame_end   = fe_q;
  assign o_stall_count        = stall_q;

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Bench for pixel_stream_feeder: queue-based reference model, per-cycle
// comparison, directed scenarios with literal expectations, random traffic.
module tb_pixel_stream_feeder;

  localparam int W = 100;
  localparam int H = 24;
  localparam int DEPTH = 16;

  logic        clk_fpga = 1'b0;
  logic        reset_fpga = 1'b1;
  logic        i_flush = 1'b0;
  logic [4:0]  o_fifo_level;
  logic [15:0] o_stall_count;

  int vectors = 0;
  int miscompares = 0;

  pixel_stream_feeder_if pif ();

  pixel_stream_feeder dut (
    .clk_fpga      (clk_fpga),
    .reset_fpga    (reset_fpga),
    .i_flush       (i_flush),
    .pix_if        (pif),
    .o_fifo_level  (o_fifo_level),
    .o_stall_count (o_stall_count)
  );

  always #5 clk_fpga = ~clk_fpga;

  // Reference model: queue contents, linear raster index, delivery snapshot.
  int q[$];
  int m_idx, m_stall, m_pix, m_x, m_y;
  bit m_valid, m_fs, m_fe;

  always @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      q.delete();
      m_idx = 0; m_stall = 0; m_pix = 0; m_x = 0; m_y = 0;
      m_valid = 0; m_fs = 0; m_fe = 0;
    end else if (i_flush) begin
      q.delete();
      m_idx = 0; m_stall = 0;
      m_valid = 0; m_fs = 0; m_fe = 0;
    end else begin
      bit was_empty, was_full;
      was_empty = (q.size() == 0);
      was_full  = (q.size() == DEPTH);
      m_valid = 0; m_fs = 0; m_fe = 0;
      if (pif.i_pixel_request && !was_empty) begin
        m_pix = q.pop_front();
        m_x = m_idx % W;
        m_y = m_idx / W;
        m_fs = (m_idx == 0);
        m_fe = (m_idx == W * H - 1);
        m_valid = 1;
        m_idx = (m_idx + 1) % (W * H);
      end
      if (pif.i_pixel_request && was_empty && m_stall < 65535) m_stall++;
      if (pif.i_pixel_valid && !was_full) q.push_back(int'(pif.i_pixel));
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk_fpga) begin
    if (!reset_fpga) begin
      check("cyc_valid", pif.o_pixel_valid, m_valid);
      check("cyc_pixel", pif.o_pixel, m_pix);
      check("cyc_x", pif.o_x, m_x);
      check("cyc_y", pif.o_y, m_y);
      check("cyc_fstart", pif.o_frame_start, m_fs);
      check("cyc_fend", pif.o_frame_end, m_fe);
      check("cyc_level", o_fifo_level, q.size());
      check("cyc_ready", pif.o_pixel_ready, q.size() < DEPTH);
      check("cyc_stall", o_stall_count, m_stall);
    end
  end

  task automatic step();
    @(posedge clk_fpga);
    #1;
  endtask

  task automatic drive(input bit v, input int pix, input bit req, input bit fl);
    pif.i_pixel_valid   = v;
    pif.i_pixel         = 12'(pix);
    pif.i_pixel_request = req;
    i_flush             = fl;
  endtask

  initial begin
    int k, pin;
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk_fpga);
    #1 reset_fpga = 1'b0;
    check("rst_valid", pif.o_pixel_valid, 0);
    check("rst_ready", pif.o_pixel_ready, 1);
    check("rst_level", o_fifo_level, 0);

    // Three pixels delivered back to back.
    drive(1, 'h101, 0, 0); step();
    drive(1, 'h102, 0, 0); step();
    drive(1, 'h103, 0, 0); step();
    drive(0, 0, 1, 0); step();
    check("t1_valid0", pif.o_pixel_valid, 1);
    check("t1_pix0", pif.o_pixel, 'h101);
    check("t1_xy0", {pif.o_x, pif.o_y}, 0);
    check("t1_fs0", pif.o_frame_start, 1);
    step();
    check("t1_pix1", pif.o_pixel, 'h102);
    check("t1_x1", pif.o_x, 1);
    check("t1_fs1", pif.o_frame_start, 0);
    step();
    check("t1_pix2", pif.o_pixel, 'h103);
    check("t1_x2", pif.o_x, 2);
    check("t1_level", o_fifo_level, 0);
    drive(0, 0, 0, 0); step();
    check("t1_idle", pif.o_pixel_valid, 0);

    // Requests against an empty FIFO.
    drive(0, 0, 1, 0);
    repeat (5) step();
    check("t2_stall", o_stall_count, 5);
    check("t2_valid", pif.o_pixel_valid, 0);
    drive(1, 'h0AA, 0, 0); step();
    drive(0, 0, 1, 0); step();
    check("t2_valid_aa", pif.o_pixel_valid, 1);
    check("t2_pix_aa", pif.o_pixel, 'h0AA);
    check("t2_x_aa", pif.o_x, 3);

    // Fill to full, hold 17th word, free one slot.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, $urandom_range(0, 4095), 0, 0); step();
    end
    check("t3_level16", o_fifo_level, 16);
    check("t3_ready0", pif.o_pixel_ready, 0);
    drive(1, 'h5A5, 0, 0); step();
    check("t3_held", o_fifo_level, 16);
    drive(1, 'h5A5, 1, 0); step();
    check("t3_ready1", pif.o_pixel_ready, 1);
    check("t3_level15", o_fifo_level, 15);
    drive(1, 'h5A5, 0, 0); step();
    check("t3_accept", o_fifo_level, 16);
    drive(0, 0, 1, 0);
    repeat (DEPTH) step();
    check("t3_last", pif.o_pixel, 'h5A5);
    check("t3_drained", o_fifo_level, 0);

    // Full frame plus one pixel.
    drive(0, 0, 0, 1); step();
    k = 0; pin = 0;
    for (int c = 0; c < 2600 && k < W * H + 1; c++) begin
      drive(1, pin, 1, 0); pin++;
      step();
      if (pif.o_pixel_valid) begin
        if (k == 99) begin
          check("t4_99_xy", {pif.o_x, pif.o_y}, {12'd99, 12'd0});
        end else if (k == 100) begin
          check("t4_100_xy", {pif.o_x, pif.o_y}, {12'd0, 12'd1});
        end else if (k == 2399) begin
          check("t4_2399_xy", {pif.o_x, pif.o_y}, {12'd99, 12'd23});
          check("t4_2399_fe", pif.o_frame_end, 1);
          check("t4_2399_pix", pif.o_pixel, 2399);
        end else if (k == 2400) begin
          check("t4_2400_xy", {pif.o_x, pif.o_y}, 0);
          check("t4_2400_fs", pif.o_frame_start, 1);
        end
        k++;
      end
    end
    check("t4_count", k, W * H + 1);
    drive(0, 0, 1, 0); step();
    drive(0, 0, 0, 0); step();

    // Flush with push and request in the same cycle.
    drive(0, 0, 0, 1); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 'h200 + i, 0, 0); step();
    end
    drive(0, 0, 1, 0); step(); step();
    check("t5_pre_level", o_fifo_level, 2);
    drive(1, 'h3FF, 1, 1); step();
    check("t5_level", o_fifo_level, 0);
    check("t5_valid", pif.o_pixel_valid, 0);
    check("t5_stall", o_stall_count, 0);
    drive(1, 'h321, 1, 0); step();
    drive(0, 0, 1, 0); step();
    check("t5_pix", pif.o_pixel, 'h321);
    check("t5_xy", {pif.o_x, pif.o_y}, 0);
    check("t5_fs", pif.o_frame_start, 1);
    drive(0, 0, 0, 0); step();

    // Random traffic with varying densities.
    for (int seg = 0; seg < 4; seg++) begin
      int pv, pr;
      pv = (seg % 2 == 0) ? 80 : 30;
      pr = (seg < 2) ? 30 : 85;
      for (int c = 0; c < 500; c++) begin
        drive($urandom_range(0, 99) < pv, $urandom_range(0, 4095),
              $urandom_range(0, 99) < pr, $urandom_range(0, 199) == 0);
        step();
      end
    end

    // Asynchronous reset with five entries buffered.
    drive(0, 0, 0, 1); step();
    for (int i = 0; i < 5; i++) begin
      drive(1, 'h400 + i, 0, 0); step();
    end
    drive(0, 0, 1, 0); step();
    check("t6_level4", o_fifo_level, 4);
    drive(1, 'h4FF, 0, 0); step();
    check("t6_level5", o_fifo_level, 5);
    #2 reset_fpga = 1'b1;
    #1;
    check("t6_level", o_fifo_level, 0);
    check("t6_ready", pif.o_pixel_ready, 1);
    check("t6_valid", pif.o_pixel_valid, 0);
    check("t6_pixel", pif.o_pixel, 0);
    check("t6_xy", {pif.o_x, pif.o_y}, 0);
    check("t6_marks", {pif.o_frame_start, pif.o_frame_end}, 0);
    check("t6_stall", o_stall_count, 0);
    drive(0, 0, 0, 0);
    @(negedge clk_fpga);
    #1 reset_fpga = 1'b0;
    step(); step();
    check("t6_post_level", o_fifo_level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
